// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter issue stage: widths, FSM encoding
// and the entry bundle held by both the main and skid registers.
package shift_pkg;

   localparam int DW     = 32;
   localparam int RW     = 5;
   localparam int SAW    = 5;
   localparam int SA_LUI = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [SAW-1:0] sa;
      logic           right;
      logic           arith;
      logic [RW-1:0]  dest;
   } entry_t;

   // LUI travels as a left shift with the arith bit set.
   function automatic logic is_lui(input logic right, input logic arith);
      return !right && arith;
   endfunction

endpackage

// File: rtl/sa_resolve.sv
// Combinational shift-amount selection: immediate shamt, low bits of rs,
// or the fixed LUI amount.
module sa_resolve
   import shift_pkg::*;
(
   input  logic           sel_var,
   input  logic [SAW-1:0] rs_low,
   input  logic [SAW-1:0] shamt,
   input  logic           right,
   input  logic           arith,
   output logic [SAW-1:0] sa
);

   localparam logic [SAW-1:0] SA_LUI_W = SAW'(SA_LUI);

   always_comb begin
      sa = shamt;
      if (is_lui(right, arith)) begin
         sa = SA_LUI_W;
      end else if (sel_var) begin
         sa = rs_low;
      end
   end

endmodule

// File: rtl/shift_issue_buffer.sv
// Two-entry skid buffer feeding the execute-stage shifter. in_ready is a flop
// so the decode-side ready path never sees downstream combinational logic.
module shift_issue_buffer
   import shift_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  in_data,
   input  logic [DW-1:0]  in_rs,
   input  logic [SAW-1:0] in_shamt,
   input  logic           in_var,
   input  logic           in_right,
   input  logic           in_arith,
   input  logic [RW-1:0]  in_dest,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_data,
   output logic [31:0]    out_sa,
   output logic           out_right,
   output logic           out_arith,
   output logic [RW-1:0]  out_dest
);

   state_t         state_q, state_d;
   entry_t         main_q, main_d;
   entry_t         skid_q, skid_d;
   logic           in_ready_q;
   logic [SAW-1:0] sa_res;
   entry_t         in_entry;
   logic           accept;
   logic           take;

   // Only the low SAW bits of rs select the amount.
   logic unused_rs_hi;
   assign unused_rs_hi = &{1'b0, in_rs[DW-1:SAW]};

   sa_resolve u_sa_resolve (
      .sel_var (in_var),
      .rs_low  (in_rs[SAW-1:0]),
      .shamt   (in_shamt),
      .right   (in_right),
      .arith   (in_arith),
      .sa      (sa_res)
   );

   always_comb begin
      in_entry       = '0;
      in_entry.data  = in_data;
      in_entry.sa    = sa_res;
      in_entry.right = in_right;
      in_entry.arith = in_arith;
      in_entry.dest  = in_dest;
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid && in_ready_q;
   assign take      = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // A same-cycle take already left; everything else is killed.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = in_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && take) begin
                  main_d = in_entry;
               end else if (accept) begin
                  skid_d  = in_entry;
                  state_d = ST_FULL;
               end else if (take) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (take) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != ST_FULL);
      end
   end

   assign out_data  = main_q.data;
   assign out_sa    = {{(32-SAW){1'b0}}, main_q.sa};
   assign out_right = main_q.right;
   assign out_arith = main_q.arith;
   assign out_dest  = main_q.dest;

endmodule
